add_sequencer: RTL and testbench

Multi-word addition controller that shares one 5-bit ripple-carry adder slice between two requesters. Each request presents two operands of `5*WORDS` bits. The block arbitrates round-robin, then feeds the operands through the slice one 5-bit word per cycle with a registered carry. It returns the full-width sum and final carry-out on a valid/ready response port. It sits between the operand producers and the shared 5-bit adder datapath built from the team's full-adder cells.

---
 rtl/add_sequencer.sv | 156 +++++++++++++++
 tb/tb_add_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sequencer.sv
// add_sequencer: two requesters share one 5-bit ripple-carry slice.
// A granted operand pair is added one 5-bit word per cycle, starting at the
// least significant word, with the carry held in a register between words.
// The full-width sum and the final carry-out are then returned on a
// valid/ready response port.
module add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [5*WORDS-1:0] req0_x,
  input  logic [5*WORDS-1:0] req0_y,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [5*WORDS-1:0] req1_x,
  input  logic [5*WORDS-1:0] req1_y,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [5*WORDS-1:0] rsp_sum,
  output logic               rsp_cout,
  output logic               rsp_id,
  output logic               busy
);

  localparam int W = 5 * WORDS;
  localparam logic [3:0] K_LAST = 4'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         next_state;

  // Operand registers shift down one word per RUN cycle, so the slice always
  // reads their low 5 bits; the sum register fills from the top.
  logic [W-1:0]   x_reg;
  logic [W-1:0]   y_reg;
  logic [W-1:0]   sum_reg;
  logic [W-1:0]   sum_next;
  logic           carry;
  logic           cout_reg;
  logic           id_reg;
  logic           last;      // requester granted most recently
  logic [3:0]     k;         // index of the word being added

  logic           idle;
  logic           grant0;
  logic           grant1;
  logic           take0;
  logic           take1;
  logic           take;

  logic [4:0]     slice_sum;
  logic           slice_cout;

  // Round-robin arbitration: a lone requester wins; on a tie the requester
  // not granted last wins. Ready is withheld while reset is asserted.
  assign grant0 = req0_valid && (!req1_valid || last);
  assign grant1 = req1_valid && (!req0_valid || !last);
  assign idle   = (state == IDLE) && !rst;

  assign req0_ready = idle && grant0;
  assign req1_ready = idle && grant1;

  assign take0 = req0_valid && req0_ready;
  assign take1 = req1_valid && req1_ready;
  assign take  = take0 || take1;

  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign rsp_sum   = sum_reg;
  assign rsp_cout  = cout_reg;
  assign rsp_id    = id_reg;

  // The one and only adder: a 5-bit ripple of full-adder cells, carry-in
  // from the carry register.
  always_comb begin : g_ripple_slice
    logic c;
    // NOTE: every variable written in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    slice_sum = '0;
    c = carry;
    for (int i = 0; i < 5; i++) begin
      slice_sum[i] = x_reg[i] ^ y_reg[i] ^ c;
      c = (x_reg[i] & y_reg[i]) | (c & (x_reg[i] ^ y_reg[i]));
    end
    slice_cout = c;
  end

  // New slice sum enters at the top; after WORDS shifts word 0 sits at bit 0.
  if (WORDS == 1) begin : g_sum_one
    assign sum_next = slice_sum;
  end else begin : g_sum_many
    assign sum_next = {slice_sum, sum_reg[W-1:5]};
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: accept in IDLE, WORDS slice cycles, hold in DONE.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (take) next_state = RUN;
      RUN:     if (k == K_LAST) next_state = DONE;
      DONE:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: capture on handshake, then one word per RUN cycle.
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are reset too, because the response
    // outputs read straight from them and must be 0 after reset.
    if (rst) begin
      x_reg    <= '0;
      y_reg    <= '0;
      sum_reg  <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      id_reg   <= 1'b0;
      last     <= 1'b1;
      k        <= '0;
    end else if (take) begin
      x_reg  <= take1 ? req1_x : req0_x;
      y_reg  <= take1 ? req1_y : req0_y;
      id_reg <= take1;
      last   <= take1;
      k      <= '0;
      carry  <= 1'b0;
    end else if (state == RUN) begin
      x_reg   <= x_reg >> 5;
      y_reg   <= y_reg >> 5;
      sum_reg <= sum_next;
      carry   <= slice_cout;
      k       <= k + 4'd1;
      if (k == K_LAST) begin
        cout_reg <= slice_cout;
      end
    end
  end

endmodule

// File: tb/tb_add_sequencer.sv
// Testbench for add_sequencer: directed tests on a WORDS=4 instance checked
// every cycle against a transaction-level model, plus WORDS=1 and WORDS=16
// instances exercised with random operands and response backpressure.
module tb_add_sequencer;

  localparam int MW  = 4;
  localparam int MWW = 5 * MW;

  logic           clk;
  logic           rst;
  logic           req0_valid, req0_ready, req1_valid, req1_ready;
  logic [MWW-1:0] req0_x, req0_y, req1_x, req1_y;
  logic           rsp_valid, rsp_ready, rsp_cout, rsp_id, busy;
  logic [MWW-1:0] rsp_sum;

  int errors = 0;
  int checks = 0;
  bit mdl_on = 0;

  add_sequencer #(.WORDS(MW)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .rsp_id(rsp_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction model: m_age is -1 when idle, otherwise cycles since accept;
  // the result is presented once WORDS cycles have elapsed.
  int           m_age  = -1;
  bit           m_last = 1'b1;
  logic [MWW:0] m_res  = '0;
  bit           m_id   = 1'b0;

  function automatic bit m_rdy0();
    return !rst && m_age < 0 && req0_valid && (!req1_valid || m_last);
  endfunction

  function automatic bit m_rdy1();
    return !rst && m_age < 0 && req1_valid && (!req0_valid || !m_last);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_age = -1; m_last = 1'b1; m_res = '0; m_id = 1'b0;
    end else if (m_age < 0) begin
      if (m_rdy0()) begin
        m_res = {1'b0, req0_x} + {1'b0, req0_y}; m_id = 1'b0; m_last = 1'b0; m_age = 0;
      end else if (m_rdy1()) begin
        m_res = {1'b0, req1_x} + {1'b0, req1_y}; m_id = 1'b1; m_last = 1'b1; m_age = 0;
      end
    end else if (m_age < MW) begin
      m_age = m_age + 1;
    end else if (rsp_ready) begin
      m_age = -1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (mdl_on) begin
      check("cyc_rsp_valid", rsp_valid, m_age == MW);
      check("cyc_busy", busy, m_age >= 0);
      check("cyc_req0_ready", req0_ready, m_rdy0());
      check("cyc_req1_ready", req1_ready, m_rdy1());
      check("cyc_one_ready", req0_ready & req1_ready, 0);
      if (m_age == MW) begin
        check("cyc_rsp_result", {rsp_cout, rsp_sum}, m_res);
        check("cyc_rsp_id", rsp_id, m_id);
      end
    end
  end

  task automatic accept(input bit id, input logic [MWW-1:0] x, input logic [MWW-1:0] y);
    bit got;
    if (id) begin req1_x = x; req1_y = y; req1_valid = 1'b1; end
    else    begin req0_x = x; req0_y = y; req0_valid = 1'b1; end
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin got = 1; break; end
    end
    check("accept_seen", got, 1);
    tick();
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  // Called right after the accept edge with rsp_ready high.
  task automatic expect_rsp(input string nm, input logic [MWW:0] exp, input bit eid, input int elat);
    int lat;
    bit got;
    lat = 0; got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin got = 1; break; end
    end
    check({nm, "_seen"}, got, 1);
    check({nm, "_latency"}, lat, elat);
    check({nm, "_result"}, {rsp_cout, rsp_sum}, exp);
    check({nm, "_id"}, rsp_id, eid);
    tick();
  endtask

  // Sweep instances for the smallest and largest legal WORDS.
  for (genvar g = 0; g < 2; g++) begin : g_sw
    localparam int SW  = (g == 0) ? 1 : 16;
    localparam int SWW = 5 * SW;
    logic           s_rst, v0, r0, v1, r1, rv, rr, cout, id, bsy;
    logic [SWW-1:0] x0, y0, x1, y1, sum;
    bit             done;

    add_sequencer #(.WORDS(SW)) u_sw (
      .clk(clk), .rst(s_rst),
      .req0_valid(v0), .req0_ready(r0), .req0_x(x0), .req0_y(y0),
      .req1_valid(v1), .req1_ready(r1), .req1_x(x1), .req1_y(y1),
      .rsp_valid(rv), .rsp_ready(rr), .rsp_sum(sum),
      .rsp_cout(cout), .rsp_id(id), .busy(bsy)
    );

    initial begin
      logic [SWW-1:0] xs, ys;
      logic [SWW:0]   e;
      int             lat;
      bit             got, who;
      done = 0; s_rst = 1; v0 = 0; v1 = 0; rr = 0;
      x0 = '0; y0 = '0; x1 = '0; y1 = '0;
      repeat (2) @(posedge clk);
      #1 s_rst = 0;
      for (int n = 0; n < 12; n++) begin
        who = n[0];
        if (n == 0) begin xs = '1; ys = SWW'(1); end
        else begin
          xs = SWW'({$urandom, $urandom, $urandom});
          ys = SWW'({$urandom, $urandom, $urandom});
        end
        if (who) begin x1 = xs; y1 = ys; v1 = 1; end
        else     begin x0 = xs; y0 = ys; v0 = 1; end
        got = 0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (who ? r1 : r0) begin got = 1; break; end
        end
        check("sweep_accept", got, 1);
        @(posedge clk);
        #1 v0 = 0; v1 = 0;
        x0 = ~x0; y0 = ~y0; x1 = ~x1; y1 = ~y1;
        e = {1'b0, xs} + {1'b0, ys};
        lat = 0; got = 0;
        for (int i = 0; i < 60; i++) begin
          @(negedge clk);
          lat++;
          if (rv) begin got = 1; break; end
        end
        check("sweep_valid_seen", got, 1);
        check("sweep_latency", lat, SW + 1);
        for (int i = 0; i < 8; i++) begin
          @(posedge clk);
          #1 rr = (i >= 3) || ($urandom_range(0, 1) == 1);
          @(negedge clk);
          check("sweep_valid_held", rv, 1);
          if (rr) begin
            check("sweep_result", {cout, sum}, e);
            check("sweep_id", id, who);
            @(posedge clk);
            #1 rr = 0;
            break;
          end
        end
      end
      done = 1;
    end
  end

  initial begin
    int   exp_tie[3];
    bit   exp_tid[3];
    bit   got;
    exp_tie = '{300, 3000, 300};
    exp_tid = '{1'b0, 1'b1, 1'b0};
    rst = 1; rsp_ready = 1;
    req0_valid = 0; req1_valid = 0;
    req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;

    // Reset values, with a request pending during reset.
    tick();
    mdl_on = 1;
    req0_valid = 1;
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_rsp_cout", rsp_cout, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 0; rst = 0;
    tick();

    // Tie after reset: grants 0, 1, 0.
    req0_x = 20'd100;  req0_y = 20'd200;
    req1_x = 20'd1000; req1_y = 20'd2000;
    req0_valid = 1; req1_valid = 1;
    for (int r = 0; r < 3; r++) begin
      got = 0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (rsp_valid) begin got = 1; break; end
      end
      check("tie_seen", got, 1);
      check("tie_id", rsp_id, exp_tid[r]);
      check("tie_result", {rsp_cout, rsp_sum}, exp_tie[r]);
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    tick();

    // Single request and carry boundaries.
    accept(0, 20'd12345, 20'd54321);
    expect_rsp("single", 21'd66666, 0, MW + 1);
    accept(1, 20'd31, 20'd1);
    expect_rsp("carry_word", 21'd32, 1, MW + 1);
    accept(0, 20'd1048575, 20'd1);
    expect_rsp("carry_out", 21'h100000, 0, MW + 1);

    // Backpressure with requester 1 waiting.
    rsp_ready = 0;
    accept(0, 20'd777, 20'd888);
    req1_x = 20'd5; req1_y = 20'd6; req1_valid = 1;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1; break; end
    end
    check("bp_seen", got, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("bp_valid_held", rsp_valid, 1);
      check("bp_result_held", {rsp_cout, rsp_sum}, 21'd1665);
      check("bp_id_held", rsp_id, 0);
      check("bp_ready_low", {req0_ready, req1_ready}, 0);
    end
    tick();
    rsp_ready = 1;
    @(negedge clk);
    check("bp_ready_at_rsp_hs", req1_ready, 0);
    tick();
    @(negedge clk);
    check("bp_accept_next", req1_ready, 1);
    tick();
    req1_valid = 0;
    expect_rsp("bp_next", 21'd11, 1, MW + 1);

    // Reset at RUN cycle k=2.
    accept(0, 20'd500, 20'd600);
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_result", {rsp_cout, rsp_sum}, 0);
    check("midrst_id", rsp_id, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_rsp", rsp_valid, 0);
    end
    tick();
    req0_x = 20'd3; req0_y = 20'd4; req1_x = 20'd9; req1_y = 20'd9;
    req0_valid = 1; req1_valid = 1;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin got = 1; break; end
    end
    check("midrst_tie_seen", got, 1);
    check("midrst_tie_grant", {req1_ready, req0_ready}, 2'b01);
    tick();
    req0_valid = 0; req1_valid = 0;
    expect_rsp("midrst_fresh", 21'd7, 0, MW + 1);

    // Wait for the sweep instances.
    got = 0;
    for (int i = 0; i < 20000; i++) begin
      if (g_sw[0].done && g_sw[1].done) begin got = 1; break; end
      @(posedge clk);
    end
    check("sweep_done", got, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
